mcu_sequencer: RTL and testbench

// - Cycle-state generator for the 12-bit MCU; its state_o drives the control decoder's State input.
// - Runs program-load mode: accepts program words over a valid/ready stream and writes them to program memory.
// - Then steps FETCH->DECODE->EXECUTE per instruction, with halt detection, run/pause and single-step debug.
// - Also provides restart-to-load and a retired-instruction counter.

---
 rtl/mcu_pkg.sv | 41 ++++
 rtl/mcu_sequencer_if.sv | 29 ++
 rtl/mcu_sequencer_prog_load_ctr.sv | 37 +++
 rtl/mcu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mcu_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// Purpose: shared state codes, halt opcode and sequencer FSM encoding for the 12-bit MCU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mcu_pkg;

    // Cycle-state codes as seen by the control decoder's State input.
    localparam logic [1:0] CODE_LOAD    = 2'b00;
    localparam logic [1:0] CODE_FETCH   = 2'b01;
    localparam logic [1:0] CODE_DECODE  = 2'b10;
    localparam logic [1:0] CODE_EXECUTE = 2'b11;

    // Instr_Reg[11:8] value that stops the sequencer.
    localparam logic [3:0] HALT_OP = 4'b0001;

    typedef enum logic [2:0] {
        S_LOAD,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_PAUSE,
        S_HALT
    } seqState_t;

    // PAUSE re-presents FETCH (idempotent at an unchanged PC); HALT holds
    // EXECUTE with the halt instruction in IR so the decoder asserts nothing.
    function automatic logic [1:0] stateCode(input seqState_t s);
        logic [1:0] code;
        code = CODE_LOAD;
        case (s)
            S_LOAD:   code = CODE_LOAD;
            S_FETCH:  code = CODE_FETCH;
            S_DECODE: code = CODE_DECODE;
            S_EXEC:   code = CODE_EXECUTE;
            S_PAUSE:  code = CODE_FETCH;
            S_HALT:   code = CODE_EXECUTE;
            default:  code = CODE_LOAD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mcu_sequencer_if.sv
// Purpose: program-load stream (valid/ready + last) and program-memory write port.
// Latency: n/a (wires only).
// Backpressure: load_ready from the slave (sequencer) side throttles the loader.
// Ports: load_valid/load_data/load_last -> slave, load_ready <- slave,
//        pm_wr_en/pm_wr_addr/pm_wr_data <- slave (registered memory write).
interface mcu_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              pm_wr_en;
    logic [ADDR_W-1:0] pm_wr_addr;
    logic [DATA_W-1:0] pm_wr_data;

    // Environment side: drives the loader stream, observes memory writes.
    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, pm_wr_en, pm_wr_addr, pm_wr_data
    );

    // Sequencer side.
    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, pm_wr_en, pm_wr_addr, pm_wr_data
    );
endinterface

// File: rtl/mcu_sequencer_prog_load_ctr.sv
// Purpose: program-load write address and load-complete flag with PROG_DEPTH terminal count.
// Latency: addr/loadDone update 1 cycle after the accepted word.
// Backpressure: none itself; the caller deasserts ready once loadDone is set.
// Ports: clk, rst, clr (restart at addr 0), hs (word accepted), last (final word),
//        addr (address of the next word), loadDone (program complete).
module prog_load_ctr #(
    parameter int PROG_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              hs,
    input  logic              last,
    output logic [ADDR_W-1:0] addr,
    output logic              loadDone
);

    logic atEnd;
    assign atEnd = (addr == ADDR_W'(PROG_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr     <= '0;
            loadDone <= 1'b0;
        end else if (hs) begin
            // The terminal word completes the load instead of incrementing,
            // so addr never wraps back onto word 0.
            if (last || atEnd) begin
                loadDone <= 1'b1;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcu_sequencer.sv
// Purpose: MCU cycle-state generator: program load, FETCH/DECODE/EXECUTE stepping, halt, pause, single-step.
// Latency: 3 cycles per instruction; program-memory write 1 cycle after each accepted loader word.
// Backpressure: load_ready only in LOAD before completion; load_start while running waits for the instruction boundary.
// Ports: clk, rst (sync, active high), instr_reg, loadBus (loader stream + memory write),
//        load_start, run_en, step_req, state_o, pc_clr, halted, paused, instr_count.
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter int         PROG_DEPTH = 256,
    parameter int         ADDR_W     = 8,
    parameter int         DATA_W     = 12,
    parameter int         CNT_W      = 16,
    parameter logic [3:0] HALT_OP    = mcu_pkg::HALT_OP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  instr_reg,
    mcu_sequencer_if.slave     loadBus,
    input  logic               load_start,
    input  logic               run_en,
    input  logic               step_req,
    output logic [1:0]         state_o,
    output logic               pc_clr,
    output logic               halted,
    output logic               paused,
    output logic [CNT_W-1:0]   instr_count
);

    seqState_t         stateQ, stateD;
    logic              enterLoad;
    logic              pendQ;
    logic              stepQ;
    logic [CNT_W-1:0]  cntQ;
    logic              pmWrEnQ;
    logic [ADDR_W-1:0] pmWrAddrQ;
    logic [DATA_W-1:0] pmWrDataQ;
    logic [ADDR_W-1:0] loadAddr;
    logic              loadDone;
    logic              loadReady;
    logic              hs;
    logic              ctrClr;
    logic              isHalt;
    logic [DATA_W-5:0] unusedIrOperand;

    // Only the opcode field matters for sequencing.
    assign isHalt          = (instr_reg[DATA_W-1 -: 4] == HALT_OP);
    assign unusedIrOperand = instr_reg[DATA_W-5:0];

    assign loadReady = !rst && (stateQ == S_LOAD) && !loadDone;
    assign hs        = loadBus.load_valid && loadReady;

    // Counter restarts on any entry into LOAD and on the final LOAD cycle,
    // so addr is 0 again by the time FETCH begins.
    assign ctrClr = enterLoad || ((stateQ == S_LOAD) && loadDone);

    prog_load_ctr #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_loadCtr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctrClr),
        .hs       (hs),
        .last     (loadBus.load_last),
        .addr     (loadAddr),
        .loadDone (loadDone)
    );

    always_comb begin
        stateD    = stateQ;
        enterLoad = 1'b0;
        case (stateQ)
            S_LOAD: begin
                if (loadDone) stateD = S_FETCH;
            end
            S_FETCH:  stateD = S_DECODE;
            S_DECODE: stateD = S_EXEC;
            S_EXEC: begin
                // A restart requested during this very cycle is honoured here too.
                if (isHalt) begin
                    stateD = S_HALT;
                end else if (pendQ || load_start) begin
                    stateD    = S_LOAD;
                    enterLoad = 1'b1;
                end else if (!run_en || stepQ) begin
                    stateD = S_PAUSE;
                end else begin
                    stateD = S_FETCH;
                end
            end
            S_PAUSE: begin
                if (load_start) begin
                    stateD    = S_LOAD;
                    enterLoad = 1'b1;
                end else if (step_req || run_en) begin
                    stateD = S_FETCH;
                end
            end
            S_HALT: begin
                if (load_start) begin
                    stateD    = S_LOAD;
                    enterLoad = 1'b1;
                end
            end
            default: begin
                stateD    = S_LOAD;
                enterLoad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= S_LOAD;
            pendQ     <= 1'b0;
            stepQ     <= 1'b0;
            cntQ      <= '0;
            pmWrEnQ   <= 1'b0;
            pmWrAddrQ <= '0;
            pmWrDataQ <= '0;
        end else begin
            stateQ  <= stateD;
            pmWrEnQ <= hs;
            if (hs) begin
                pmWrAddrQ <= loadAddr;
                pmWrDataQ <= loadBus.load_data;
            end

            if (enterLoad) begin
                pendQ <= 1'b0;
            end else if (load_start && ((stateQ == S_FETCH) || (stateQ == S_DECODE) ||
                                        (stateQ == S_EXEC))) begin
                pendQ <= 1'b1;
            end

            // A step requested together with run_en still returns to PAUSE.
            if ((stateQ == S_PAUSE) && (stateD == S_FETCH)) begin
                stepQ <= step_req;
            end else if (stateQ == S_EXEC) begin
                stepQ <= 1'b0;
            end

            // EXEC always lasts exactly one cycle, so every EXEC cycle retires one.
            if (stateQ == S_EXEC) begin
                cntQ <= cntQ + 1'b1;
            end
        end
    end

    // Outputs are forced to their idle values for as long as rst is held.
    assign state_o            = rst ? CODE_LOAD : stateCode(stateQ);
    assign pc_clr             = !rst && (stateQ == S_LOAD) && loadDone;
    assign halted             = !rst && (stateQ == S_HALT);
    assign paused             = !rst && (stateQ == S_PAUSE);
    assign instr_count        = cntQ;
    assign loadBus.load_ready = loadReady;
    assign loadBus.pm_wr_en   = pmWrEnQ && !rst;
    assign loadBus.pm_wr_addr = pmWrAddrQ;
    assign loadBus.pm_wr_data = pmWrDataQ;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Purpose: directed self-checking bench for mcu_sequencer with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: loader stream honours load_ready as sampled by the bench.
module tb_mcu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] instr_reg;
    logic        load_start;
    logic        run_en;
    logic        step_req;
    logic [1:0]  state_o;
    logic        pc_clr;
    logic        halted;
    logic        paused;
    logic [15:0] instr_count;

    int vecCnt  = 0;
    int missCnt = 0;

    mcu_sequencer_if #(.ADDR_W(8), .DATA_W(12)) bus ();

    mcu_sequencer #(
        .PROG_DEPTH (256),
        .ADDR_W     (8),
        .DATA_W     (12),
        .CNT_W      (16),
        .HALT_OP    (4'b0001)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_reg   (instr_reg),
        .loadBus     (bus),
        .load_start  (load_start),
        .run_en      (run_en),
        .step_req    (step_req),
        .state_o     (state_o),
        .pc_clr      (pc_clr),
        .halted      (halted),
        .paused      (paused),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            missCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, wr, zeroHits, lastA, lastD, sawDrop;

        rst            = 1'b1;
        instr_reg      = 12'h801;
        load_start     = 1'b0;
        run_en         = 1'b1;
        step_req       = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_state", state_o, 2'b00);
        chk("rst_wr_en", bus.pm_wr_en, 0);
        chk("rst_pc_clr", pc_clr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_paused", paused, 0);
        chk("rst_ready", bus.load_ready, 0);
        chk("rst_count", instr_count, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.load_ready, 1);

        // Three-word load: 0x801, 0x802, 0x103 with load_last on the third
        bus.load_valid = 1'b1;
        bus.load_data  = 12'h801;
        tick();
        chk("w0_en", bus.pm_wr_en, 1);
        chk("w0_addr", bus.pm_wr_addr, 0);
        chk("w0_data", bus.pm_wr_data, 12'h801);
        bus.load_data = 12'h802;
        tick();
        chk("w1_addr", bus.pm_wr_addr, 1);
        chk("w1_data", bus.pm_wr_data, 12'h802);
        bus.load_data = 12'h103;
        bus.load_last = 1'b1;
        tick();
        chk("w2_en", bus.pm_wr_en, 1);
        chk("w2_addr", bus.pm_wr_addr, 2);
        chk("w2_data", bus.pm_wr_data, 12'h103);
        chk("w2_pc_clr", pc_clr, 1);
        chk("w2_ready", bus.load_ready, 0);
        chk("w2_state", state_o, 2'b00);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        tick();
        chk("fetch_pc_clr", pc_clr, 0);
        chk("fetch_wr_en", bus.pm_wr_en, 0);
        chk("fetch_state", state_o, 2'b01);
        tick();
        chk("decode_state", state_o, 2'b10);
        tick();
        chk("exec_state", state_o, 2'b11);
        chk("exec_count0", instr_count, 0);

        // Free-run: 30 cycles from the first FETCH retire 10 instructions
        repeat (28) tick();
        chk("run10_count", instr_count, 10);
        chk("run10_state", state_o, 2'b01);

        // Halt instruction
        instr_reg = 12'h123;
        tick();
        chk("halt_decode", state_o, 2'b10);
        tick();
        chk("halt_exec", state_o, 2'b11);
        chk("halt_exec_count", instr_count, 10);
        tick();
        chk("halt_flag", halted, 1);
        chk("halt_state", state_o, 2'b11);
        chk("halt_count", instr_count, 11);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        chk("halt_hold", halted, 1);
        chk("halt_hold_state", state_o, 2'b11);
        chk("halt_hold_count", instr_count, 11);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("restart_state", state_o, 2'b00);
        chk("restart_halted", halted, 0);
        chk("restart_ready", bus.load_ready, 1);
        instr_reg = 12'h801;

        // Full-depth stream without load_last
        hs = 0; wr = 0; zeroHits = 0; lastA = 0; lastD = 0; sawDrop = 0;
        bus.load_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bus.load_data = 12'(12'h200 + hs);
            if (bus.load_ready) hs++;
            tick();
            if (bus.pm_wr_en) begin
                wr++;
                if (bus.pm_wr_addr == 8'd0 && wr > 1) zeroHits++;
                lastA = int'(bus.pm_wr_addr);
                lastD = int'(bus.pm_wr_data);
            end
            if (hs == 256 && sawDrop == 0) begin
                sawDrop = 1;
                chk("full_ready_drop", bus.load_ready, 0);
                chk("full_pc_clr", pc_clr, 1);
                bus.load_valid = 1'b0;
            end
            if (state_o != 2'b00) break;
        end
        chk("full_handshakes", hs, 256);
        chk("full_writes", wr, 256);
        chk("full_last_addr", lastA, 255);
        chk("full_last_data", lastD, 12'h2FF);
        chk("full_addr0_rehit", zeroHits, 0);
        chk("full_drop_seen", sawDrop, 1);
        chk("full_state", state_o, 2'b01);

        // Pause mid-instruction, then single step
        tick();
        run_en = 1'b0;
        tick();
        chk("pause_exec", state_o, 2'b11);
        tick();
        chk("pause_flag", paused, 1);
        chk("pause_state", state_o, 2'b01);
        chk("pause_count", instr_count, 12);
        repeat (2) tick();
        chk("pause_hold", paused, 1);
        chk("pause_hold_count", instr_count, 12);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_fetch_paused", paused, 0);
        chk("step_fetch", state_o, 2'b01);
        tick();
        chk("step_decode", state_o, 2'b10);
        tick();
        chk("step_exec", state_o, 2'b11);
        tick();
        chk("step_repause", paused, 1);
        chk("step_repause_state", state_o, 2'b01);
        chk("step_count", instr_count, 13);

        // Restart from PAUSE, then reset during load at addr 5
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("pause_restart", state_o, 2'b00);
        bus.load_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.load_data = 12'(12'h300 + k);
            tick();
        end
        chk("partial_addr", bus.pm_wr_addr, 4);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", bus.load_ready, 0);
        chk("mid_rst_wr_en", bus.pm_wr_en, 0);
        chk("mid_rst_state", state_o, 2'b00);
        chk("mid_rst_pc_clr", pc_clr, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_paused", paused, 0);
        tick();
        chk("mid_rst_count", instr_count, 0);
        chk("mid_rst_wr_en2", bus.pm_wr_en, 0);
        rst = 1'b0;
        bus.load_data = 12'hABC;
        tick();
        chk("reload_en", bus.pm_wr_en, 1);
        chk("reload_addr", bus.pm_wr_addr, 0);
        chk("reload_data", bus.pm_wr_data, 12'hABC);
        bus.load_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
